// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble instruction, stage payload
// widths and field offsets, and the elastic-stage state encoding.
package pipe_pkg;

  localparam logic [6:0]  OPCODE_NOP  = 7'b0010011;
  localparam logic [31:0] BUBBLE_INSN = {25'd0, OPCODE_NOP};

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 168;
  localparam int EX_MEM_W = 112;
  localparam int MEM_WB_W = 72;

  localparam int IF_ID_PC_LSB    = 0;
  localparam int IF_ID_INSN_LSB  = 32;
  localparam int ID_EX_PC_LSB    = 0;
  localparam int ID_EX_RS1_LSB   = 32;
  localparam int ID_EX_RS2_LSB   = 64;
  localparam int ID_EX_IMM_LSB   = 96;
  localparam int ID_EX_CTRL_LSB  = 128;
  localparam int EX_MEM_ALU_LSB  = 0;
  localparam int EX_MEM_WD_LSB   = 32;
  localparam int EX_MEM_CTRL_LSB = 64;
  localparam int MEM_WB_RES_LSB  = 0;
  localparam int MEM_WB_CTRL_LSB = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_st_e;

  function automatic logic [1:0] st_occ(stage_st_e s);
    unique case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_slot.sv
// One payload register with load and clear-to-bubble.
// Clear wins over load so squashes drop same-cycle writes.
module skid_slot #(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = BUBBLE;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register, optionally with a
// two-entry skid buffer so in_ready comes straight from a flop.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter bit                SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  if (SKID) begin : g_skid
    stage_st_e         state_q;
    stage_st_e         state_d;
    logic              rdy_q;
    logic              rdy_d;
    logic              push;
    logic              pop;
    logic              main_ld;
    logic              main_clr;
    logic              skid_ld;
    logic              skid_clr;
    logic [DATA_W-1:0] main_din;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    assign push = in_valid & rdy_q;
    assign pop  = (state_q != ST_EMPTY) & out_ready;

    always_comb begin
      state_d  = state_q;
      main_ld  = 1'b0;
      main_clr = 1'b0;
      skid_ld  = 1'b0;
      skid_clr = 1'b0;
      main_din = in_data;
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_ld = 1'b1;
          end else if (push) begin
            state_d = ST_FULL;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d  = ST_ONE;
            main_ld  = 1'b1;
            main_din = skid_q;
            skid_clr = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      // squash drops any accepted payload; the pop still happened
      if (reset || flush) begin
        state_d  = ST_EMPTY;
        main_clr = 1'b1;
        skid_clr = 1'b1;
      end
      rdy_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_EMPTY;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        rdy_q   <= rdy_d;
      end
    end

    skid_slot #(
      .DATA_W(DATA_W),
      .BUBBLE(BUBBLE)
    ) u_main (
      .clk  (clk),
      .clear(main_clr),
      .load (main_ld),
      .d    (main_din),
      .q    (main_q)
    );

    skid_slot #(
      .DATA_W(DATA_W),
      .BUBBLE(BUBBLE)
    ) u_skid (
      .clk  (clk),
      .clear(skid_clr),
      .load (skid_ld),
      .d    (in_data),
      .q    (skid_q)
    );

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = st_occ(state_q);
  end else begin : g_single
    logic              valid_q;
    logic              valid_d;
    logic              rdy;
    logic              push;
    logic              pop;
    logic              main_clr;
    logic [DATA_W-1:0] main_q;

    assign rdy  = ~valid_q | out_ready;
    assign push = in_valid & rdy;
    assign pop  = valid_q & out_ready;

    always_comb begin
      valid_d = push | (valid_q & ~out_ready);
      if (flush) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    assign main_clr = reset | flush | (pop & ~push);

    skid_slot #(
      .DATA_W(DATA_W),
      .BUBBLE(BUBBLE)
    ) u_main (
      .clk  (clk),
      .clear(main_clr),
      .load (push),
      .d    (in_data),
      .q    (main_q)
    );

    assign in_ready  = rdy;
    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign occupancy = {1'b0, valid_q};
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid and single-register variants
// checked each cycle against a queue model plus directed scenarios.
module tb_pipe_stage_reg;

  localparam logic [15:0] BUB = 16'hF000;

  logic        clk;
  logic        rs   [2];
  logic        fl   [2];
  logic        iv   [2];
  logic        irdy [2];
  logic [15:0] id   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [15:0] od   [2];
  logic [1:0]  occ  [2];

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  logic [15:0] mq [2][$];

  pipe_stage_reg #(
    .DATA_W(16),
    .BUBBLE(BUB),
    .SKID(1'b1)
  ) dut1 (
    .clk(clk), .reset(rs[1]), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .occupancy(occ[1])
  );

  pipe_stage_reg #(
    .DATA_W(16),
    .BUBBLE(BUB),
    .SKID(1'b0)
  ) dut0 (
    .clk(clk), .reset(rs[0]), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .occupancy(occ[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // queue model: capacity 2 (skid) or 1, outputs from the queue head
  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) begin
        int          sz;
        logic        e_v;
        logic        e_r;
        logic [15:0] e_d;
        sz  = mq[k].size();
        e_v = (sz > 0);
        e_d = e_v ? mq[k][0] : BUB;
        e_r = (k == 1) ? (sz < 2) : ((sz == 0) || ordy[k]);
        chk($sformatf("m%0d_out_valid", k), 16'(ov[k]), 16'(e_v));
        chk($sformatf("m%0d_out_data", k), od[k], e_d);
        chk($sformatf("m%0d_occupancy", k), 16'(occ[k]), 16'(sz));
        chk($sformatf("m%0d_in_ready", k), 16'(irdy[k]), 16'(e_r));
        if (rs[k] || fl[k]) begin
          mq[k].delete();
        end else begin
          if (e_v && ordy[k]) void'(mq[k].pop_front());
          if (iv[k] && e_r) mq[k].push_back(id[k]);
        end
      end
    end
  end

  task automatic step(input int k, input logic v, input logic [15:0] d,
                      input logic r, input logic f, input logic x);
    @(posedge clk);
    #1;
    iv[k]   = v;
    id[k]   = d;
    ordy[k] = r;
    fl[k]   = f;
    rs[k]   = x;
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rs[k] = 1'b1; fl[k] = 1'b0; iv[k] = 1'b0;
      id[k] = 16'h0; ordy[k] = 1'b1;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    run = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 16'(ov[1]), 16'd0);
    chk("rst_out_data", od[1], BUB);
    chk("rst_occupancy", 16'(occ[1]), 16'd0);
    chk("rst_in_ready1", 16'(irdy[1]), 16'd1);
    chk("rst_in_ready0", 16'(irdy[0]), 16'd1);
    step(0, 0, 0, 1, 0, 0);

    step(1, 1, 16'd1, 1, 0, 0);
    chk("strm_first", od[1], BUB);
    chk("strm_rdy_first", 16'(irdy[1]), 16'd1);
    for (int i = 2; i <= 5; i++) begin
      step(1, 1, 16'(i), 1, 0, 0);
      chk("strm_data", od[1], 16'(i - 1));
      chk("strm_rdy", 16'(irdy[1]), 16'd1);
    end

    step(1, 1, 16'd6, 0, 0, 0);
    chk("bp_hold5", od[1], 16'd5);
    chk("bp_occ1", 16'(occ[1]), 16'd1);
    step(1, 1, 16'd7, 0, 0, 0);
    chk("bp_occ2", 16'(occ[1]), 16'd2);
    chk("bp_rdy_lo1", 16'(irdy[1]), 16'd0);
    step(1, 1, 16'd7, 0, 0, 0);
    chk("bp_rdy_lo2", 16'(irdy[1]), 16'd0);
    step(1, 1, 16'd7, 1, 0, 0);
    chk("bp_rdy_lo3", 16'(irdy[1]), 16'd0);
    chk("bp_still5", od[1], 16'd5);
    step(1, 1, 16'd7, 1, 0, 0);
    chk("bp_rdy_back", 16'(irdy[1]), 16'd1);
    chk("bp_out6", od[1], 16'd6);
    step(1, 0, 16'd0, 1, 0, 0);
    chk("bp_out7", od[1], 16'd7);
    step(1, 0, 16'd0, 1, 0, 0);
    chk("bp_drained", 16'(ov[1]), 16'd0);

    step(1, 1, 16'd8, 0, 0, 0);
    step(1, 1, 16'd9, 0, 0, 0);
    chk("fl_occ1", 16'(occ[1]), 16'd1);
    step(1, 1, 16'd10, 0, 1, 0);
    chk("fl_full", 16'(occ[1]), 16'd2);
    step(1, 0, 16'd0, 0, 0, 0);
    chk("fl_valid", 16'(ov[1]), 16'd0);
    chk("fl_occ", 16'(occ[1]), 16'd0);
    chk("fl_data", od[1], BUB);
    chk("fl_rdy", 16'(irdy[1]), 16'd1);

    step(1, 1, 16'd4, 1, 0, 0);
    step(1, 1, 16'd11, 1, 0, 0);
    chk("pp_head4", od[1], 16'd4);
    step(1, 0, 16'd0, 1, 0, 0);
    chk("pp_head11", od[1], 16'd11);
    chk("pp_occ", 16'(occ[1]), 16'd1);
    step(1, 0, 16'd0, 1, 0, 0);

    step(1, 1, 16'd20, 0, 0, 0);
    step(1, 1, 16'd21, 0, 0, 0);
    step(1, 1, 16'd22, 0, 0, 1);
    chk("rm_occ2", 16'(occ[1]), 16'd2);
    step(1, 0, 16'd0, 0, 0, 0);
    chk("rm_occ", 16'(occ[1]), 16'd0);
    chk("rm_valid", 16'(ov[1]), 16'd0);
    chk("rm_data", od[1], BUB);
    chk("rm_rdy", 16'(irdy[1]), 16'd1);

    step(0, 1, 16'd30, 0, 0, 0);
    chk("s0_rdy_empty", 16'(irdy[0]), 16'd1);
    step(0, 1, 16'd31, 0, 0, 0);
    chk("s0_valid", 16'(ov[0]), 16'd1);
    chk("s0_rdy_stall", 16'(irdy[0]), 16'd0);
    step(0, 1, 16'd31, 1, 0, 0);
    chk("s0_rdy_same", 16'(irdy[0]), 16'd1);
    chk("s0_out30", od[0], 16'd30);
    step(0, 1, 16'd32, 1, 0, 0);
    chk("s0_out31", od[0], 16'd31);
    step(0, 0, 16'd0, 1, 0, 0);
    chk("s0_out32", od[0], 16'd32);
    step(0, 0, 16'd0, 1, 0, 0);
    chk("s0_empty", 16'(ov[0]), 16'd0);

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        id[k]   = 16'($urandom);
        ordy[k] = ($urandom_range(0, 2) != 0);
        fl[k]   = ($urandom_range(0, 49) == 0);
        rs[k]   = ($urandom_range(0, 99) == 0);
      end
    end
    @(negedge clk);
    #1;
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
